sb_sram_slave: RTL and testbench
================================

Name: sb_sram_slave

Overview:
- Bus-slave responder on the system bus: the target end of the transactions issued by jtag_if, the CPU and other bus masters.
- Decodes an address window, serves single and burst reads and writes from an internal byte-enabled word RAM, and signals end, busy and error per bus protocol.
- Replaces the emulated SDRAM slave in simulation and serves as on-chip scratch/debug RAM on the Gecko5.
- All outputs are OR'd onto the bus, so every output is 0 whenever the block is not actively responding.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base of window; aligned to window size.
- ADDR_WIDTH, 12, word-address bits; window = 4*2^ADDR_WIDTH bytes.
- READ_LATENCY, 2, cycles from begin_transaction sample to first read beat; legal range 2..15.

Ports:
- sb_clock_i  in  1  system clock, all logic on rising edge
- sb_reset_n_i  in  1  reset, asynchronous assert, active-low
- sb_begin_transaction_i  in  1  transaction start; address phase
- sb_end_transaction_i  in  1  bus end (master-driven on writes)
- sb_data_valid_i  in  1  write data beat valid
- sb_address_data_i  in  32  address on begin, write data on beats
- sb_byte_enables_i  in  4  byte lanes, sampled on begin
- sb_burst_size_i  in  8  beats minus one, sampled on begin
- sb_read_n_write_i  in  1  1 = read, 0 = write, sampled on begin
- sb_error_i  in  1  bus error (arbiter or other slave)
- sb_address_data_o  out  32  read data; 0 when not driving
- sb_data_valid_o  out  1  read beat valid
- sb_end_transaction_o  out  1  read transaction end, one-cycle pulse
- sb_busy_o  out  1  stall write beats
- sb_error_o  out  1  protocol error, one-cycle pulse

Behaviour:
- Reset (sb_reset_n_i=0, async): all outputs 0, state IDLE, counters 0. RAM contents undefined.
- Reset mid-transaction: same as above, taking effect immediately.
- Select: in IDLE, begin_transaction=1 and address_data[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2].
  - On select: latch word address [ADDR_WIDTH+1:2], beats = burst_size+1 (1..256), read_n_write, byte_enables.
  - Address bits [1:0] are ignored.
  - Unselected begins are ignored; outputs stay 0.
  - begin_transaction outside IDLE is ignored.
- States: IDLE, RD_WAIT, RD_BURST, RD_END, WR_BURST, WR_ERR.
- Read path:
  - IDLE -> RD_WAIT on select. RD_WAIT counts READ_LATENCY-1 cycles while the RAM is prefetched.
  - RD_BURST: data_valid_o=1 with address_data_o=RAM word for one beat per cycle, back-to-back, no gaps.
  - First beat appears exactly READ_LATENCY cycles after the begin cycle.
  - Word address increments by 1 per beat and wraps modulo 2^ADDR_WIDTH.
  - After the last beat: RD_END drives end_transaction_o=1 for one cycle, data_valid_o=0, then IDLE.
  - Read byte_enables are ignored; the full word is returned.
- Write path:
  - IDLE -> WR_BURST on select.
  - Each cycle with data_valid_i=1 and busy_o=0 writes address_data_i to RAM, masked by the latched byte_enables; address increments with wrap.
  - A beat presented while busy_o=1 is not taken; the master holds the data.
  - Master end_transaction_i in WR_BURST -> IDLE. If it coincides with a beat, the beat is written first.
  - A beat arriving after the expected beat count -> WR_ERR: error_o=1 for one cycle, extra data discarded, then IDLE.
  - Without the optional feature, busy_o is constantly 0.
- sb_error_i=1 in any non-IDLE state: abort to IDLE next cycle, outputs 0 immediately (combinationally gated); no RAM write in that cycle.
- Zero-beat case is impossible: burst_size=0 means 1 beat.

Optional Feature:
- SB_SLAVE_BUSY_INJECT_EN defined:
  - An 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) advances every cycle in WR_BURST.
  - busy_o = lfsr[0] & lfsr[3] while in WR_BURST.
  - Purpose: stresses master stall handling.
- Undefined: busy_o tied 0, LFSR absent.

Decomposition:
- Package sb_slave_pkg holds:
  - state enum sb_slave_state_t.
  - constants SB_BURST_W=8, SB_DATA_W=32, SB_BE_W=4.
  - LFSR taps/seed constants.
- Sub-module sb_sram_mem: single-port synchronous-read RAM, 2^ADDR_WIDTH x 32, per-byte write enables, one-cycle read latency.

Test Plan:
- Preload word 0x400 = 32'hDEAD_BEEF; read begin at 32'h0000_1000, burst_size 0 -> data_valid_o at begin+2 with 32'hDEAD_BEEF, end_transaction_o at begin+3, all outputs 0 after.
- Write 32'h1234_5678, be=4'hF, to 0x1000, master end; then read back -> 32'h1234_5678.
- Over 32'hDEAD_BEEF, write 32'h1234_5678 with be=4'b0011 -> readback 32'hDEAD_5678.
- ADDR_WIDTH=12: burst read burst_size=3 at word 0xFFE -> beats from words 0xFFE, 0xFFF, 0x000, 0x001 on consecutive cycles, then end pulse.
- Begin at 32'h8000_0000 (outside window) -> no output ever leaves 0.
- Write burst_size 0 with two data beats -> first written, error_o pulse on second, word+1 unchanged.
- sb_reset_n_i low during RD_BURST -> outputs 0 the same cycle, next begin served normally.
- With SB_SLAVE_BUSY_INJECT_EN: 16-beat write, then readback -> all 16 words correct; the bench counts at least one busy cycle.

Source files
------------

// File: rtl/sb_slave_pkg.sv
// Shared types and constants for the system-bus SRAM slave.
// The optional write-stall LFSR constants are used only when SB_SLAVE_BUSY_INJECT_EN is defined.
package sb_slave_pkg;

  localparam int SB_BURST_W = 8;
  localparam int SB_DATA_W  = 32;
  localparam int SB_BE_W    = 4;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1: feedback taps at bits 7,5,4,3
  localparam logic [7:0] SB_LFSR_TAPS = 8'hB8;
  localparam logic [7:0] SB_LFSR_SEED = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_BURST,
    ST_RD_END,
    ST_WR_BURST,
    ST_WR_ERR
  } sb_slave_state_t;

endpackage

// File: rtl/sb_sram_mem.sv
// Single-port word RAM with per-byte write enables and a one-cycle registered read.
module sb_sram_mem
  import sb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  sys_clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [SB_BE_W-1:0]    byte_we,
  input  logic [SB_DATA_W-1:0]  wdata,
  output logic [SB_DATA_W-1:0]  rdata
);

  logic [SB_DATA_W-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < SB_BE_W; i++) begin
      if (byte_we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sb_sram_slave.sv
// System-bus slave serving single/burst reads and writes from an internal byte-enabled RAM.
// Define SB_SLAVE_BUSY_INJECT_EN to add pseudo-random busy stalls during write bursts.
module sb_sram_slave
  import sb_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          ADDR_WIDTH   = 12,
  parameter int          READ_LATENCY = 2
) (
  input  logic                  sb_clock_i,
  input  logic                  sb_reset_n_i,
  input  logic                  sb_begin_transaction_i,
  input  logic                  sb_end_transaction_i,
  input  logic                  sb_data_valid_i,
  input  logic [SB_DATA_W-1:0]  sb_address_data_i,
  input  logic [SB_BE_W-1:0]    sb_byte_enables_i,
  input  logic [SB_BURST_W-1:0] sb_burst_size_i,
  input  logic                  sb_read_n_write_i,
  input  logic                  sb_error_i,
  output logic [SB_DATA_W-1:0]  sb_address_data_o,
  output logic                  sb_data_valid_o,
  output logic                  sb_end_transaction_o,
  output logic                  sb_busy_o,
  output logic                  sb_error_o
);

  sb_slave_state_t       state;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [SB_BURST_W:0]   beats_left;
  logic [3:0]            wait_cnt;
  logic [SB_BE_W-1:0]    be_q;
  logic [SB_DATA_W-1:0]  mem_rdata;
  logic [SB_BE_W-1:0]    mem_we;
  logic                  busy_int;
  logic                  select;
  logic                  beat_offered;
  logic                  beat_take;
  logic                  beat_extra;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^sb_address_data_i[1:0];

  assign select = (state == ST_IDLE) && sb_begin_transaction_i &&
                  (sb_address_data_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

  // A bus error blocks the write in the same cycle it is seen
  assign beat_offered = (state == ST_WR_BURST) && sb_data_valid_i && !busy_int && !sb_error_i;
  assign beat_take    = beat_offered && (beats_left != '0);
  assign beat_extra   = beat_offered && (beats_left == '0);
  assign mem_we       = beat_take ? be_q : '0;

`ifdef SB_SLAVE_BUSY_INJECT_EN
  logic [7:0] lfsr;

  always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
    if (!sb_reset_n_i)              lfsr <= SB_LFSR_SEED;
    else if (state == ST_WR_BURST)  lfsr <= {lfsr[6:0], ^(lfsr & SB_LFSR_TAPS)};
  end

  assign busy_int = (state == ST_WR_BURST) && lfsr[0] && lfsr[3];
`else
  assign busy_int = 1'b0;
`endif

  // RAM address register runs one word ahead of the beat being presented so
  // the registered read output lines up with each read beat.
  always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
    if (!sb_reset_n_i) begin
      state      <= ST_IDLE;
      word_addr  <= '0;
      beats_left <= '0;
      wait_cnt   <= '0;
      be_q       <= '0;
    end else if (state != ST_IDLE && sb_error_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (select) begin
            word_addr  <= sb_address_data_i[ADDR_WIDTH+1:2];
            beats_left <= {1'b0, sb_burst_size_i} + (SB_BURST_W+1)'(1);
            be_q       <= sb_byte_enables_i;
            wait_cnt   <= 4'(READ_LATENCY - 2);
            state      <= sb_read_n_write_i ? ST_RD_WAIT : ST_WR_BURST;
          end
        end
        ST_RD_WAIT: begin
          if (wait_cnt == '0) begin
            word_addr <= word_addr + ADDR_WIDTH'(1);
            state     <= ST_RD_BURST;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RD_BURST: begin
          word_addr  <= word_addr + ADDR_WIDTH'(1);
          beats_left <= beats_left - (SB_BURST_W+1)'(1);
          if (beats_left == (SB_BURST_W+1)'(1)) state <= ST_RD_END;
        end
        ST_RD_END: state <= ST_IDLE;
        ST_WR_BURST: begin
          if (beat_extra) begin
            state <= ST_WR_ERR;
          end else begin
            if (beat_take) begin
              word_addr  <= word_addr + ADDR_WIDTH'(1);
              beats_left <= beats_left - (SB_BURST_W+1)'(1);
            end
            if (sb_end_transaction_i) state <= ST_IDLE;
          end
        end
        ST_WR_ERR: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  sb_sram_mem #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .sys_clk (sb_clock_i),
    .addr    (word_addr),
    .byte_we (mem_we),
    .wdata   (sb_address_data_i),
    .rdata   (mem_rdata)
  );

  // Outputs are OR'd onto the bus, so all of them are forced to 0 on a bus error
  assign sb_data_valid_o      = (state == ST_RD_BURST) && !sb_error_i;
  assign sb_address_data_o    = sb_data_valid_o ? mem_rdata : '0;
  assign sb_end_transaction_o = (state == ST_RD_END) && !sb_error_i;
  assign sb_error_o           = (state == ST_WR_ERR) && !sb_error_i;
  assign sb_busy_o            = busy_int && !sb_error_i;

endmodule

// File: tb/tb_sb_sram_slave.sv
// Directed bench for sb_sram_slave: vector table of single-beat writes/reads plus burst,
// wrap, window, error and reset sequences. Build with SB_SLAVE_BUSY_INJECT_EN to cover stalls.
module tb_sb_sram_slave;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        begin_t;
  logic        end_i;
  logic        dv_i;
  logic [31:0] ad_i;
  logic [3:0]  be_i;
  logic [7:0]  burst_i;
  logic        rnw_i;
  logic        err_i;
  logic [31:0] ad_o;
  logic        dv_o;
  logic        end_o;
  logic        busy_o;
  logic        err_o;

  int n_vec  = 0;
  int n_fail = 0;
  int busy_cycles = 0;

  logic [31:0] exp_words [16];
  logic [31:0] wr_words  [16];

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  always #5 sys_clk = ~sys_clk;

  sb_sram_slave #(
    .BASE_ADDR    (32'h0000_0000),
    .ADDR_WIDTH   (12),
    .READ_LATENCY (2)
  ) dut (
    .sb_clock_i             (sys_clk),
    .sb_reset_n_i           (rst_n),
    .sb_begin_transaction_i (begin_t),
    .sb_end_transaction_i   (end_i),
    .sb_data_valid_i        (dv_i),
    .sb_address_data_i      (ad_i),
    .sb_byte_enables_i      (be_i),
    .sb_burst_size_i        (burst_i),
    .sb_read_n_write_i      (rnw_i),
    .sb_error_i             (err_i),
    .sb_address_data_o      (ad_o),
    .sb_data_valid_o        (dv_o),
    .sb_end_transaction_o   (end_o),
    .sb_busy_o              (busy_o),
    .sb_error_o             (err_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clearInputs();
    begin_t = 1'b0; end_i = 1'b0; dv_i = 1'b0; ad_i = '0;
    be_i = '0; burst_i = '0; rnw_i = 1'b0; err_i = 1'b0;
  endtask

  // Checks the exact read timing: beats from begin+2, end pulse after the last beat
  task automatic readBurst(input logic [31:0] addr, input int nbeats);
    begin_t = 1'b1; ad_i = addr; rnw_i = 1'b1; burst_i = 8'(nbeats - 1); be_i = 4'h0;
    nextCycle();
    clearInputs();
    @(negedge sys_clk);
    checkOutput("rd_wait_valid", {31'b0, dv_o}, 32'd0);
    nextCycle();
    for (int b = 0; b < nbeats; b++) begin
      @(negedge sys_clk);
      checkOutput("rd_beat_valid", {31'b0, dv_o}, 32'd1);
      checkOutput("rd_beat_data", ad_o, exp_words[b]);
      nextCycle();
    end
    @(negedge sys_clk);
    checkOutput("rd_end_pulse", {30'b0, end_o, dv_o}, 32'd2);
    checkOutput("rd_end_data", ad_o, 32'd0);
    nextCycle();
    @(negedge sys_clk);
    checkOutput("rd_after_end", {29'b0, end_o, dv_o, err_o}, 32'd0);
    nextCycle();
  endtask

  task automatic waitNotBusy();
    int tries = 0;
    @(negedge sys_clk);
    while (busy_o && tries < 64) begin
      busy_cycles++;
      tries++;
      nextCycle();
      @(negedge sys_clk);
    end
    if (tries >= 64) begin
      n_vec++;
      n_fail++;
      $display("[TB] FAIL wr_busy_timeout: busy still 1 after %0d cycles, expected release", tries);
    end
  endtask

  // extra=1 sends one beat beyond the burst length and expects the error pulse
  task automatic writeBurst(input logic [31:0] addr, input logic [3:0] be, input int nbeats, input logic extra);
    begin_t = 1'b1; ad_i = addr; rnw_i = 1'b0; burst_i = 8'(nbeats - 1); be_i = be;
    nextCycle();
    clearInputs();
    for (int b = 0; b < nbeats; b++) begin
      dv_i = 1'b1; ad_i = wr_words[b];
      waitNotBusy();
      end_i = (b == nbeats - 1) && !extra;
      nextCycle();
      end_i = 1'b0;
    end
    if (extra) begin
      dv_i = 1'b1; ad_i = 32'hBAD0_BAD0;
      waitNotBusy();
      nextCycle();
      clearInputs();
      @(negedge sys_clk);
      checkOutput("wr_err_pulse", {31'b0, err_o}, 32'd1);
      nextCycle();
    end
    clearInputs();
    @(negedge sys_clk);
    checkOutput("wr_after_end", {30'b0, err_o, dv_o}, 32'd0);
    nextCycle();
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.rnw) begin
      exp_words[0] = v.exp;
      readBurst(v.addr, 1);
    end else begin
      wr_words[0] = v.wdata;
      writeBurst(v.addr, v.be, 1, 1'b0);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b1, 32'h0000_1000, 4'h0, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h0000_1000, 4'h3, 32'h1234_5678, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_1000, 4'h0, 32'h0,         32'hDEAD_5678};
    vecs[4]  = '{1'b0, 32'h0000_1000, 4'hF, 32'h1234_5678, 32'h0};
    vecs[5]  = '{1'b1, 32'h0000_1000, 4'h0, 32'h0,         32'h1234_5678};
    vecs[6]  = '{1'b0, 32'h0000_1004, 4'hF, 32'h0000_0000, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_1004, 4'hC, 32'hAABB_CCDD, 32'h0};
    vecs[8]  = '{1'b1, 32'h0000_1004, 4'h0, 32'h0,         32'hAABB_0000};
    vecs[9]  = '{1'b0, 32'h0000_1006, 4'h1, 32'h1122_3344, 32'h0};
    vecs[10] = '{1'b1, 32'h0000_1007, 4'h0, 32'h0,         32'hAABB_0044};
    vecs[11] = '{1'b0, 32'h0000_1004, 4'h0, 32'hFFFF_FFFF, 32'h0};
    vecs[12] = '{1'b1, 32'h0000_1004, 4'h0, 32'h0,         32'hAABB_0044};

    clearInputs();
    rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    checkOutput("reset_data",  ad_o, 32'd0);
    checkOutput("reset_flags", {27'b0, dv_o, end_o, busy_o, err_o, 1'b0}, 32'd0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();

    for (int i = 0; i < 13; i++) applyStimulus(vecs[i]);

    $display("[TB] wrap burst at word 0xFFE");
    for (int i = 0; i < 4; i++) begin
      wr_words[i]  = 32'hC0DE_0000 + 32'(i);
      exp_words[i] = 32'hC0DE_0000 + 32'(i);
    end
    writeBurst(32'h0000_3FF8, 4'hF, 4, 1'b0);
    readBurst(32'h0000_3FF8, 4);
    exp_words[0] = 32'hC0DE_0002;
    readBurst(32'h0000_0000, 1);

    $display("[TB] begin outside window");
    begin_t = 1'b1; ad_i = 32'h8000_0000; rnw_i = 1'b1; burst_i = 8'd3;
    nextCycle();
    clearInputs();
    for (int c = 0; c < 6; c++) begin
      @(negedge sys_clk);
      checkOutput("unselected_quiet", ad_o | {27'b0, dv_o, end_o, busy_o, err_o, 1'b0}, 32'd0);
      nextCycle();
    end

    $display("[TB] write with one beat too many");
    wr_words[0] = 32'h5A5A_5A5A;
    writeBurst(32'h0000_1404, 4'hF, 1, 1'b0);
    wr_words[0] = 32'h1111_2222;
    writeBurst(32'h0000_1400, 4'hF, 1, 1'b1);
    exp_words[0] = 32'h1111_2222;
    exp_words[1] = 32'h5A5A_5A5A;
    readBurst(32'h0000_1400, 2);

    $display("[TB] 16-beat write and readback");
    for (int i = 0; i < 16; i++) begin
      wr_words[i]  = {16'hB000 + 16'(i), 16'h0F0F ^ 16'(i * 3)};
      exp_words[i] = wr_words[i];
    end
    writeBurst(32'h0000_2000, 4'hF, 16, 1'b0);
    readBurst(32'h0000_2000, 16);

    $display("[TB] bus error aborts");
    begin_t = 1'b1; ad_i = 32'h0000_1000; rnw_i = 1'b1; burst_i = 8'd3;
    nextCycle();
    clearInputs();
    nextCycle();
    @(negedge sys_clk);
    checkOutput("abort_pre_valid", {31'b0, dv_o}, 32'd1);
    err_i = 1'b1;
    #1;
    checkOutput("abort_gated", ad_o | {31'b0, dv_o}, 32'd0);
    nextCycle();
    err_i = 1'b0;
    @(negedge sys_clk);
    checkOutput("abort_idle", {30'b0, dv_o, end_o}, 32'd0);
    nextCycle();
    begin_t = 1'b1; ad_i = 32'h0000_1004; rnw_i = 1'b0; burst_i = 8'd0; be_i = 4'hF;
    nextCycle();
    clearInputs();
    dv_i = 1'b1; ad_i = 32'hFFFF_FFFF; err_i = 1'b1; end_i = 1'b1;
    nextCycle();
    clearInputs();
    nextCycle();
    exp_words[0] = 32'hAABB_0044;
    readBurst(32'h0000_1004, 1);

    $display("[TB] reset during read burst");
    begin_t = 1'b1; ad_i = 32'h0000_1000; rnw_i = 1'b1; burst_i = 8'd3;
    nextCycle();
    clearInputs();
    nextCycle();
    @(negedge sys_clk);
    checkOutput("rst_pre_valid", {31'b0, dv_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_burst", ad_o | {29'b0, dv_o, end_o, err_o}, 32'd0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    exp_words[0] = 32'h1234_5678;
    readBurst(32'h0000_1000, 1);

`ifdef SB_SLAVE_BUSY_INJECT_EN
    checkOutput("busy_seen", {31'b0, busy_cycles > 0}, 32'd1);
`else
    checkOutput("busy_never", 32'(busy_cycles), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
